// File: rtl/pipelined_ones_counter.sv
// rtl/pipelined_ones_counter.sv - pipelined popcount with handshake and per-frame saturating accumulation
// Optional threshold compare output enabled by defining ONES_COUNTER_THRESH_EN.
module pipelined_ones_counter #(
  parameter int WIDTH       = 127,
  parameter int PIPE_STAGES = 3,
  parameter int ACC_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic             acc_mode,
  output logic [ACC_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sat
`ifdef ONES_COUNTER_THRESH_EN
  ,
  input  logic [ACC_W-1:0] thresh,
  output logic             out_ge
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int NL = $clog2(WIDTH);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Every tree level is held as WIDTH lanes of CW bits; lanes beyond a level's
  // population are constant zero and fall away in synthesis.
  typedef logic [WIDTH-1:0][CW-1:0] vec_t;

  function automatic int level_of(int r);
    if (PIPE_STAGES < 2 || r < 0) return 0;
    return (NL * r + PIPE_STAGES - 2) / (PIPE_STAGES - 1);
  endfunction

  function automatic vec_t expand(logic [WIDTH-1:0] d);
    vec_t e;
    e = '0;
    for (int i = 0; i < WIDTH; i++) e[IW'(i)] = CW'(d[IW'(i)]);
    return e;
  endfunction

  function automatic vec_t reduce_tree(vec_t v, int lo, int hi);
    vec_t cur;
    vec_t nxt;
    int   n;
    cur = v;
    n   = WIDTH;
    for (int j = 0; j < lo; j++) n = (n + 1) / 2;
    for (int j = lo; j < hi; j++) begin
      nxt = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (2 * i + 1 < n)
          nxt[IW'(i)] = cur[IW'(2 * i)] + cur[IW'(2 * i + 1)];
        else if (2 * i < n)
          nxt[IW'(i)] = cur[IW'(2 * i)];
      end
      cur = nxt;
      n   = (n + 1) / 2;
    end
    return cur;
  endfunction

  function automatic logic [CW-1:0] count_tail(vec_t v, int lo);
    vec_t t;
    t = reduce_tree(v, lo, NL);
    return t[0];
  endfunction

  localparam int SRC_LVL = level_of(PIPE_STAGES - 2);

  logic stall;
  vec_t src;
  logic src_v, src_m, src_l;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  generate
    if (PIPE_STAGES == 1) begin : g_direct
      assign src   = expand(in_data);
      assign src_v = in_valid;
      assign src_m = acc_mode;
      assign src_l = in_last;
    end else begin : g_pipe
      vec_t d [PIPE_STAGES-1];
      logic v [PIPE_STAGES-1];
      logic m [PIPE_STAGES-1];
      logic l [PIPE_STAGES-1];

      // Bubbles advance too, so v[0] simply follows in_valid whenever not stalled.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int r = 0; r < PIPE_STAGES - 1; r++) begin
            d[r] <= '0;
            v[r] <= 1'b0;
            m[r] <= 1'b0;
            l[r] <= 1'b0;
          end
        end else if (!stall) begin
          d[0] <= expand(in_data);
          v[0] <= in_valid;
          m[0] <= acc_mode;
          l[0] <= in_last;
          for (int r = 1; r < PIPE_STAGES - 1; r++) begin
            d[r] <= reduce_tree(d[r-1], level_of(r - 1), level_of(r));
            v[r] <= v[r-1];
            m[r] <= m[r-1];
            l[r] <= l[r-1];
          end
        end
      end

      assign src   = d[PIPE_STAGES-2];
      assign src_v = v[PIPE_STAGES-2];
      assign src_m = m[PIPE_STAGES-2];
      assign src_l = l[PIPE_STAGES-2];
    end
  endgenerate

  logic [CW-1:0]    cnt;
  logic [ACC_W-1:0] acc;
  logic             sat;
  logic [ACC_W:0]   sum;
  logic             ovf;
  logic [ACC_W-1:0] acc_next;

  assign cnt      = count_tail(src, SRC_LVL);
  assign sum      = {1'b0, acc} + (ACC_W + 1)'(cnt);
  assign ovf      = sum[ACC_W];
  assign acc_next = ovf ? '1 : sum[ACC_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_count <= '0;
      out_sat   <= 1'b0;
      acc       <= '0;
      sat       <= 1'b0;
`ifdef ONES_COUNTER_THRESH_EN
      out_ge    <= 1'b0;
`endif
    end else if (!stall) begin
      out_valid <= 1'b0;
      if (src_v) begin
        if (!src_m) begin
          out_valid <= 1'b1;
          out_count <= ACC_W'(cnt);
          out_sat   <= 1'b0;
`ifdef ONES_COUNTER_THRESH_EN
          out_ge    <= (ACC_W'(cnt) >= thresh);
`endif
        end else if (src_l) begin
          out_valid <= 1'b1;
          out_count <= acc_next;
          out_sat   <= sat | ovf;
          acc       <= '0;
          sat       <= 1'b0;
`ifdef ONES_COUNTER_THRESH_EN
          out_ge    <= (acc_next >= thresh);
`endif
        end else begin
          acc <= acc_next;
          sat <= sat | ovf;
        end
      end
    end
  end

endmodule

// File: doc/pipelined_ones_counter.md
Name: pipelined_ones_counter

Overview:
- Parametrised, pipelined successor to the combinational 127-bit ones counter.
- Counts set bits in a WIDTH-bit word through a register-staged adder tree with a valid/ready handshake and full-pipeline backpressure.
- Optional per-word or per-frame accumulation mode, with a saturating accumulator.
- Sits between a word source (e.g. shift/capture logic) and a consumer of population counts.

Parameters:
- WIDTH, 127, input word width in bits (>=2).
- PIPE_STAGES, 3, register stages from accept to output (1..$clog2(WIDTH)+1); tree levels are distributed evenly across stages.
- ACC_W, 16, accumulator and result width (>= CW, where CW = $clog2(WIDTH+1)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_data  input  WIDTH  word to count.
- in_valid  input  1  in_data/in_last/acc_mode are valid.
- in_ready  output  1  block can accept a word this cycle.
- in_last  input  1  last word of a frame (used only in accumulate mode).
- acc_mode  input  1  0 = per-word count; 1 = per-frame accumulated count.
- out_count  output  ACC_W  result.
- out_valid  output  1  out_count is valid.
- out_ready  input  1  consumer accepts the result.
- out_sat  output  1  frame total saturated (valid with out_valid).

Behaviour:
- Reset (async, any time): all pipeline valid bits, the accumulator and the frame-open flag clear immediately.
  - out_valid=0, out_count=0, out_sat=0.
  - A partial frame is discarded.
  - in_ready=1 from the first cycle after rst deasserts.
- Handshake:
  - stall = out_valid & !out_ready.
  - in_ready = !stall, combinational.
  - A word transfers when in_valid & in_ready.
  - Whenever stall=0, every stage advances, including bubbles.
  - While stall=1 all stages hold and out_count/out_valid/out_sat stay stable.
- Per-word transfer:
  - acc_mode and in_last are carried alongside the data through the pipeline.
  - Sampled values apply per word; mode may change on any word.
- Popcount:
  - Stage 0 registers the input.
  - The adder tree sums bit groups; each level's sum is 1 bit wider than its operands; odd leftovers are zero-padded.
  - Final count width is CW, zero-extended to ACC_W.
- Latency: a word accepted in cycle T appears at the output stage in cycle T+PIPE_STAGES, absent stalls. Stalls add cycles one for one.
- Final stage, acc_mode=0:
  - out_valid=1, out_count = popcount, out_sat=0.
  - Any open accumulation is unaffected.
- Final stage, acc_mode=1:
  - acc_next = acc + popcount, saturating at 2^ACC_W-1; the sticky sat flag is set on overflow.
  - in_last=0: the accumulator updates and no output is produced (bubble).
  - in_last=1:
    - out_count = acc_next, out_sat = sticky sat | overflow this word, out_valid=1.
    - Accumulator and sat then clear for the next frame.
  - A single-word frame (in_last=1 on the first word) outputs that word's count.
- Throughput: one word per cycle when out_ready stays high.
- Edge counts: all-zero word counts 0; all-ones word counts WIDTH.

Optional Feature:
- Macro: ONES_COUNTER_THRESH_EN.
- Defined:
  - Adds input thresh [ACC_W-1:0] and output out_ge [1].
  - out_ge = (out_count >= thresh), registered with out_count and valid with out_valid.
  - thresh is sampled at the final-stage update.
- Undefined: the ports are absent and there is no comparator logic.

Test Plan:
- Reset/idle: assert rst mid-stream with 2 words in flight -> out_valid drops immediately; no stale output after release; in_ready=1.
- Per-word, defaults: feed 0, all-ones, 0x1 with out_ready=1 -> outputs 0, 127, 1 in order, each exactly 3 cycles after acceptance, back-to-back.
- Backpressure: hold out_ready=0 for 5 cycles with a continuous in_valid stream -> in_ready=0 while out_valid=1; no word lost or duplicated; the sequence after release matches the reference popcounts.
- Accumulate frame: acc_mode=1, words all-ones, all-ones, 0x7 (last) -> single output 257, out_sat=0; no outputs for the first two words.
- Saturation: ACC_W=8, WIDTH=127, frame of 3 all-ones words -> out_count=255, out_sat=1; next frame of one 0x3 word -> 2, out_sat=0.
- Threshold (ONES_COUNTER_THRESH_EN): thresh=64, words with 63 and 64 ones in per-word mode -> out_ge 0 then 1.
